// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: SPI mode-0 master that reads one 5-byte joystick frame per
// poll period and publishes X/Y deflection and buttons atomically.
module jstk_spi_reader #(
  parameter int HALF_DIV    = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1666666
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] X_POS,
  output logic [9:0] Y_POS,
  output logic [2:0] buttons,
  output logic       sample_valid
);

  localparam int BIT_LEN = 2 * HALF_DIV;
  localparam int CNT_MAX = (SS_SETUP > BIT_LEN) ?
                           ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP) :
                           ((BIT_LEN > BYTE_GAP) ? BIT_LEN : BYTE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int POLL_W  = $clog2(POLL_PERIOD + 1);

  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_LEN - 1);
  localparam logic [CNT_W-1:0]  HALF_C     = CNT_W'(HALF_DIV);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [2:0]          r_bit, w_bit_nxt;
  logic [2:0]          r_byte, w_byte_nxt;
  logic [7:0]          r_cmd, w_cmd_nxt;
  logic [POLL_W-1:0]   r_poll;
  logic [7:0]          r_sr, w_sr_nxt;
  logic                w_sample;
  logic                w_byte_end;
  logic                w_ss_nxt, w_sclk_nxt, w_mosi_nxt;

  // Shadow copies of the received frame; outputs only load from these at DONE.
  logic [7:0]          r_x_lo, r_y_lo;
  logic [1:0]          r_x_hi, r_y_hi;

  logic                r_ss, r_sclk, r_mosi, r_sv;
  logic [9:0]          r_x, r_y;
  logic [2:0]          r_btn;

  // Next-state, bit/byte sequencing and next values of the SPI pins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_cmd_nxt   = r_cmd;
    w_sample    = 1'b0;
    w_byte_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_poll == '0) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_cmd_nxt   = {6'b100000, led};
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // sclk is high from HALF_DIV onward; the first high cycle samples miso.
        w_sample = (r_cnt == HALF_C);
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_bit_nxt  = '0;
            w_byte_end = 1'b1;
            if (r_byte == 3'd4) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_GAP;
              w_byte_nxt  = r_byte + 3'd1;
            end
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pins are registered from the next state so they never glitch on decode.
    w_ss_nxt   = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) ||
                   (w_state_nxt == S_GAP));
    w_sclk_nxt = (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= HALF_C);
    w_mosi_nxt = w_ss_nxt ? 1'b0 : w_cmd_nxt[3'd7 - w_bit_nxt];
    w_sr_nxt   = w_sample ? {r_sr[6:0], miso} : r_sr;
  end

  // Control state, poll counter, SPI pins and published results.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_poll  <= '0;
      r_ss    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_sv    <= 1'b0;
      r_x     <= 10'd512;
      r_y     <= 10'd512;
      r_btn   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_poll  <= (r_poll == POLL_LAST) ? '0 : r_poll + POLL_W'(1);
      r_ss    <= w_ss_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_sv    <= (w_state_nxt == S_DONE);
      // Byte 4 completes on the edge into DONE; publish everything together.
      if (w_state_nxt == S_DONE) begin
        r_x   <= {r_x_hi, r_x_lo};
        r_y   <= {r_y_hi, r_y_lo};
        r_btn <= w_sr_nxt[2:0];
      end
    end
  end

  // Receive shift register, command latch and per-byte shadow capture.
  always_ff @(posedge clk) begin
    r_sr  <= w_sr_nxt;
    r_cmd <= w_cmd_nxt;
    if (w_byte_end) begin
      case (r_byte)
        3'd0:    r_x_lo <= w_sr_nxt;
        3'd1:    r_x_hi <= w_sr_nxt[1:0];
        3'd2:    r_y_lo <= w_sr_nxt;
        3'd3:    r_y_hi <= w_sr_nxt[1:0];
        default: ;
      endcase
    end
  end

  assign ss           = r_ss;
  assign sclk         = r_sclk;
  assign mosi         = r_mosi;
  assign X_POS        = r_x;
  assign Y_POS        = r_y;
  assign buttons      = r_btn;
  assign sample_valid = r_sv;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: joystick slave model plus frame-level reference.
module tb_jstk_spi_reader;

  localparam int HALF_DIV    = 2;
  localparam int SS_SETUP    = 4;
  localparam int BYTE_GAP    = 3;
  localparam int POLL_PERIOD = 200;
  localparam int TXN_LEN     = 1 + SS_SETUP + 5 * 16 * HALF_DIV + 4 * BYTE_GAP + 1;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] led;
  logic       miso;
  logic       ss, sclk, mosi;
  logic [9:0] X_POS, Y_POS;
  logic [2:0] buttons;
  logic       sample_valid;

  int checks = 0;
  int errors = 0;

  jstk_spi_reader #(
    .HALF_DIV   (HALF_DIV),
    .SS_SETUP   (SS_SETUP),
    .BYTE_GAP   (BYTE_GAP),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .led         (led),
    .miso        (miso),
    .ss          (ss),
    .sclk        (sclk),
    .mosi        (mosi),
    .X_POS       (X_POS),
    .Y_POS       (Y_POS),
    .buttons     (buttons),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Joystick slave: presents the 40-bit frame MSB first, next bit after each sclk fall.
  logic [39:0] tx_stream = '0;
  logic [5:0]  slv_idx   = 6'd40;
  logic [39:0] mosi_log  = '0;
  int          rise_cnt  = 0;
  logic        ss_prev   = 1'b1;
  logic        sclk_prev = 1'b0;

  assign miso = (slv_idx < 6'd40) ? tx_stream[6'd39 - slv_idx] : 1'b0;

  always @(negedge clk) begin
    if (ss_prev && !ss) begin
      slv_idx  = 6'd0;
      rise_cnt = 0;
    end else if (!ss && sclk_prev && !sclk && slv_idx < 6'd40) begin
      slv_idx = slv_idx + 6'd1;
    end
    if (!ss && !sclk_prev && sclk) begin
      rise_cnt = rise_cnt + 1;
      mosi_log = {mosi_log[38:0], mosi};
    end
    ss_prev   = ss;
    sclk_prev = sclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [9:0] cur_x = 10'd512;

  // One full poll: load slave bytes, wait for the result pulse, compare to the reference.
  task automatic do_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [1:0] l,
                        input int exp_cyc);
    int         cyc, ss_low, ix, iy, ib;
    bit         xstable;
    logic [7:0] cmd;
    logic [39:0] emosi;
    ix    = int'(b1 % 8'd4) * 256 + int'(b0);
    iy    = int'(b3 % 8'd4) * 256 + int'(b2);
    ib    = int'(b4 % 8'd8);
    cmd   = 8'h80 + 8'(l);
    emosi = {cmd, cmd, cmd, cmd, cmd};
    tx_stream = {b0, b1, b2, b3, b4};
    led       = l;
    cyc = 0; ss_low = 0; xstable = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!ss) begin
        ss_low++;
        if (ss_low == 1) led = 2'($urandom);
      end
      if (!sample_valid && X_POS !== cur_x) xstable = 1'b0;
    end while (!sample_valid && cyc < 1000);
    chk("sv_seen",   64'(sample_valid), 64'(1));
    chk("sv_period", 64'(cyc), 64'(exp_cyc));
    chk("ss_low",    64'(ss_low), 64'(TXN_LEN - 2));
    chk("x_pos",     64'(X_POS), 64'(ix));
    chk("y_pos",     64'(Y_POS), 64'(iy));
    chk("buttons",   64'(buttons), 64'(ib));
    chk("ss_done",   64'(ss), 64'(1));
    chk("rises",     64'(rise_cnt), 64'(40));
    chk("mosi",      64'(mosi_log), 64'(emosi));
    chk("x_stable",  64'(xstable), 64'(1));
    @(negedge clk);
    chk("sv_width",  64'(sample_valid), 64'(0));
    chk("x_hold",    64'(X_POS), 64'(ix));
    cur_x = ix[9:0];
  endtask

  initial begin
    int k;
    bit sv_seen;
    clr_n = 1'b0;
    led   = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_x",    64'(X_POS), 64'(512));
    chk("rst_y",    64'(Y_POS), 64'(512));
    chk("rst_btn",  64'(buttons), 64'(0));
    chk("rst_ss",   64'(ss), 64'(1));
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_sv",   64'(sample_valid), 64'(0));

    // Start a transaction, then abort it with reset during byte 2
    tx_stream = {8'h34, 8'h02, 8'hC5, 8'h01, 8'h05};
    led       = 2'b10;
    clr_n     = 1'b1;
    k = 0; sv_seen = 1'b0;
    while (rise_cnt < 20 && k < 400) begin
      @(negedge clk);
      k++;
      if (sample_valid) sv_seen = 1'b1;
    end
    chk("abort_reach", 64'(rise_cnt >= 20), 64'(1));
    chk("abort_ss_in", 64'(ss), 64'(0));
    #2 clr_n = 1'b0;
    #1;
    chk("abort_ss",   64'(ss), 64'(1));
    chk("abort_sclk", 64'(sclk), 64'(0));
    chk("abort_x",    64'(X_POS), 64'(512));
    chk("abort_y",    64'(Y_POS), 64'(512));
    chk("abort_btn",  64'(buttons), 64'(0));
    repeat (4) begin
      @(negedge clk);
      if (sample_valid) sv_seen = 1'b1;
    end
    chk("abort_no_sv", 64'(sv_seen), 64'(0));

    // Release at a negedge: first transaction starts on the next edge
    clr_n = 1'b1;
    do_txn(8'h34, 8'h02, 8'hC5, 8'h01, 8'h05, 2'b10, TXN_LEN - 1);

    // Upper bits of the high bytes are ignored
    do_txn(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b01, POLL_PERIOD - 1);

    // Random frames and LED values, back-to-back polls
    for (int i = 0; i < 6; i++) begin
      do_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             2'($urandom), POLL_PERIOD - 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
